// File: rtl/ac_sgpio_pkg.sv
// ac_sgpio_pkg: shared state encoding, frame layout and CPU ID encodings for the SGPIO status link
package ac_sgpio_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} sgpioState_e;
  localparam int FRAME_BITS = 16;
  localparam int POS_SYS_OK = 15;
  localparam int POS_CPU_MISMATCH = 14;
  localparam int POS_HBM = 13;
  localparam int POS_SOCKET_REMOVED = 12;
  localparam int POS_SKT_OCC = 10;
  localparam int POS_PROC_ID_CPU0 = 8;
  localparam int POS_PROC_ID_CPU1 = 6;
  localparam int POS_PKG_ID_CPU0 = 3;
  localparam int POS_PKG_ID_CPU1 = 0;
  localparam logic [1:0] PROC_ID_SPR = 2'b00;
  localparam logic [1:0] PROC_ID_GNR = 2'b10;
  localparam logic [2:0] PKG_ID_NON_MCP = 3'b000;
  localparam logic [2:0] PKG_ID_HBM = 3'b010;
  function automatic logic [FRAME_BITS-1:0] packFrame(
    input logic sysOk, cpuMismatch, hbm, socketRemoved,
    input logic [1:0] sktOcc, procId0, procId1,
    input logic [2:0] pkgId0, pkgId1
  );
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[POS_SYS_OK] = sysOk;
    f[POS_CPU_MISMATCH] = cpuMismatch;
    f[POS_HBM] = hbm;
    f[POS_SOCKET_REMOVED] = socketRemoved;
    f[POS_SKT_OCC +: 2] = sktOcc;
    f[POS_PROC_ID_CPU0 +: 2] = procId0;
    f[POS_PROC_ID_CPU1 +: 2] = procId1;
    f[POS_PKG_ID_CPU0 +: 3] = pkgId0;
    f[POS_PKG_ID_CPU1 +: 3] = pkgId1;
    return f;
  endfunction
endpackage

// File: rtl/ac_sys_status_sgpio_tx_if.sv
// ac_sys_status_sgpio_tx_if: status inputs from system-check and SGPIO pins toward the BMC
interface ac_sys_status_sgpio_tx_if;
  logic iEnable;
  logic iSYS_OK;
  logic iCPU_MISMATCH;
  logic iHBM;
  logic iSOCKET_REMOVED;
  logic [1:0] ivCPU_SKT_OCC;
  logic [1:0] ivPROC_ID_CPU0;
  logic [1:0] ivPROC_ID_CPU1;
  logic [2:0] ivPKG_ID_CPU0;
  logic [2:0] ivPKG_ID_CPU1;
  logic oSCLK;
  logic oSLOAD;
  logic oSDATA;
  logic oFRAME_DONE;
  modport master (
    input iEnable, iSYS_OK, iCPU_MISMATCH, iHBM, iSOCKET_REMOVED,
    input ivCPU_SKT_OCC, ivPROC_ID_CPU0, ivPROC_ID_CPU1, ivPKG_ID_CPU0, ivPKG_ID_CPU1,
    output oSCLK, oSLOAD, oSDATA, oFRAME_DONE
  );
  modport slave (
    output iEnable, iSYS_OK, iCPU_MISMATCH, iHBM, iSOCKET_REMOVED,
    output ivCPU_SKT_OCC, ivPROC_ID_CPU0, ivPROC_ID_CPU1, ivPKG_ID_CPU0, ivPKG_ID_CPU1,
    input oSCLK, oSLOAD, oSDATA, oFRAME_DONE
  );
endinterface

// File: rtl/ac_sgpio_clk_div.sv
// ac_sgpio_clk_div: half-period counter producing SCLK rise/fall strobes while enabled
module ac_sgpio_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iEnable,
  output logic oTickRise,
  output logic oTickFall
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  logic [7:0] divCnt;
  logic phaseHigh;
  logic halfDone;
  assign halfDone = iEnable && divCnt == DIV_LAST;
  assign oTickRise = halfDone && !phaseHigh;
  assign oTickFall = halfDone && phaseHigh;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      divCnt <= '0;
      phaseHigh <= 1'b0;
    end else if (!iEnable) begin
      divCnt <= '0;
      phaseHigh <= 1'b0;
    end else begin
      divCnt <= halfDone ? 8'd0 : (divCnt == 8'hFF ? divCnt : divCnt + 8'd1);
      phaseHigh <= phaseHigh ^ halfDone;
    end
  end
endmodule

// File: rtl/ac_sys_status_sgpio_tx.sv
// ac_sys_status_sgpio_tx: streams 16-bit system-check/strap frames to the BMC over SCLK/SLOAD/SDATA
module ac_sys_status_sgpio_tx
  import ac_sgpio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYCLES = 32
) (
  input logic iClk,
  input logic iRst_n,
  ac_sys_status_sgpio_tx_if.master bus
);
  localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES - 1);
  sgpioState_e state, stateNext;
  logic [FRAME_BITS-1:0] frame, shReg;
  logic [3:0] bitCnt;
  logic [9:0] gapCnt;
  logic tickRise, tickFall, lastFall, startFrame;
  logic sclk, sload, sdata, frameDone;
  ac_sgpio_clk_div #(.CLK_DIV(CLK_DIV)) uClkDiv (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iEnable(state == SHIFT),
    .oTickRise(tickRise),
    .oTickFall(tickFall)
  );
  assign frame = packFrame(bus.iSYS_OK, bus.iCPU_MISMATCH, bus.iHBM, bus.iSOCKET_REMOVED,
                           bus.ivCPU_SKT_OCC, bus.ivPROC_ID_CPU0, bus.ivPROC_ID_CPU1,
                           bus.ivPKG_ID_CPU0, bus.ivPKG_ID_CPU1);
  always_comb begin
    stateNext = state;
    lastFall = tickFall && bitCnt == 4'd15;
    case (state)
      IDLE:    stateNext = bus.iEnable ? LOAD : IDLE;
      LOAD:    stateNext = SHIFT;
      SHIFT:   stateNext = lastFall ? GAP : SHIFT;
      GAP:     stateNext = gapCnt == GAP_LAST ? (bus.iEnable ? LOAD : IDLE) : GAP;
      default: stateNext = IDLE;
    endcase
    startFrame = stateNext == LOAD;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else state <= stateNext;
  end
  // Outputs are registered from next-state decisions so LOAD already shows bit 15 and SLOAD.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shReg <= '0;
      bitCnt <= '0;
      gapCnt <= '0;
      sclk <= 1'b0;
      sload <= 1'b0;
      sdata <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      sclk <= tickRise ? 1'b1 : (tickFall ? 1'b0 : sclk);
      frameDone <= lastFall;
      gapCnt <= state == GAP ? (gapCnt == 10'h3FF ? gapCnt : gapCnt + 10'd1) : 10'd0;
      if (startFrame) begin
        shReg <= frame;
        sdata <= frame[FRAME_BITS-1];
        sload <= 1'b1;
        bitCnt <= '0;
      end else if (tickFall) begin
        shReg <= shReg << 1;
        sdata <= lastFall ? 1'b0 : shReg[FRAME_BITS-2];
        sload <= 1'b0;
        bitCnt <= bitCnt == 4'd15 ? bitCnt : bitCnt + 4'd1;
      end
    end
  end
  assign bus.oSCLK = sclk;
  assign bus.oSLOAD = sload;
  assign bus.oSDATA = sdata;
  assign bus.oFRAME_DONE = frameDone;
endmodule

// File: tb/tb_ac_sys_status_sgpio_tx.sv
// tb_ac_sys_status_sgpio_tx: directed frame vectors plus reset, coherency, enable-drop and fast-divider sequences
module tb_ac_sys_status_sgpio_tx;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic enA = 1'b0, enB = 1'b0;
  logic sysOk = 1'b0, mism = 1'b0, hbm = 1'b0, rem = 1'b0;
  logic [1:0] skt = '0, p0 = '0, p1 = '0;
  logic [2:0] k0 = '0, k1 = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  ac_sys_status_sgpio_tx_if busA ();
  ac_sys_status_sgpio_tx_if busB ();

  assign busA.iEnable = enA;
  assign busB.iEnable = enB;
  assign busA.iSYS_OK = sysOk;
  assign busB.iSYS_OK = sysOk;
  assign busA.iCPU_MISMATCH = mism;
  assign busB.iCPU_MISMATCH = mism;
  assign busA.iHBM = hbm;
  assign busB.iHBM = hbm;
  assign busA.iSOCKET_REMOVED = rem;
  assign busB.iSOCKET_REMOVED = rem;
  assign busA.ivCPU_SKT_OCC = skt;
  assign busB.ivCPU_SKT_OCC = skt;
  assign busA.ivPROC_ID_CPU0 = p0;
  assign busB.ivPROC_ID_CPU0 = p0;
  assign busA.ivPROC_ID_CPU1 = p1;
  assign busB.ivPROC_ID_CPU1 = p1;
  assign busA.ivPKG_ID_CPU0 = k0;
  assign busB.ivPKG_ID_CPU0 = k0;
  assign busA.ivPKG_ID_CPU1 = k1;
  assign busB.ivPKG_ID_CPU1 = k1;

  ac_sys_status_sgpio_tx #(.CLK_DIV(4), .GAP_CYCLES(32)) dutA (.iClk(iClk), .iRst_n(iRst_n), .bus(busA));
  ac_sys_status_sgpio_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dutB (.iClk(iClk), .iRst_n(iRst_n), .bus(busB));

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic sysOk, mism, hbm, rem;
    logic [1:0] skt, p0, p1;
    logic [2:0] k0, k1;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[5];

  // {SCLK, SLOAD, SDATA, FRAME_DONE}
  function automatic logic [3:0] outs(input bit w);
    return w ? {busB.oSCLK, busB.oSLOAD, busB.oSDATA, busB.oFRAME_DONE}
             : {busA.oSCLK, busA.oSLOAD, busA.oSDATA, busA.oFRAME_DONE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setVec(input vec_t v);
    sysOk = v.sysOk; mism = v.mism; hbm = v.hbm; rem = v.rem;
    skt = v.skt; p0 = v.p0; p1 = v.p1; k0 = v.k0; k1 = v.k1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge iClk);
  endtask

  // Waits for the next LOAD, then shifts in SDATA on each SCLK rise until FRAME_DONE.
  // action 1 clears SYS_OK during bit 10, action 2 drops enable during bit 7.
  task automatic capture(input bit w, input int action, output logic [15:0] data,
                         output int loadCyc, output int doneCyc, output int riseCnt,
                         output bit sloadOk, output int riseGap);
    int n;
    int firstRise;
    logic [3:0] o;
    bit prevSclk;
    data = '0; loadCyc = -1; doneCyc = -1; riseCnt = 0; sloadOk = 1'b1; riseGap = -1;
    firstRise = -1; n = 0; prevSclk = 1'b0;
    while (loadCyc < 0 && n < 400) begin
      @(negedge iClk); n++;
      o = outs(w);
      if (o[2]) loadCyc = cyc;
    end
    while (loadCyc >= 0 && doneCyc < 0 && n < 1000) begin
      @(negedge iClk); n++;
      o = outs(w);
      if (o[3] && !prevSclk) begin
        data = {data[14:0], o[1]};
        if (o[2] != (riseCnt == 0)) sloadOk = 1'b0;
        if (firstRise < 0) firstRise = cyc;
        else if (riseGap < 0) riseGap = cyc - firstRise;
        riseCnt++;
        if (action == 1 && riseCnt == 6) sysOk = 1'b0;
        if (action == 2 && riseCnt == 9) enA = 1'b0;
      end
      if (o[0]) doneCyc = cyc;
      prevSclk = o[3];
    end
    if (doneCyc < 0) begin
      errors++;
      checks++;
      $display("FAIL capture_timeout: got load=%0d done=%0d expected a completed frame", loadCyc, doneCyc);
    end
  endtask

  initial begin
    logic [15:0] d1, d2;
    int l1, l2, dn1, dn2, rc1, rc2, rg1, rg2, cnt;
    bit so1, so2;
    logic [3:0] acc;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b010, 3'b010, 16'hA292};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 3'b000, 16'h4100};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 3'b111, 3'b111, 16'hFFFF};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b101, 3'b011, 16'h18AB};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 16'h0000};

    @(negedge iClk);
    chk("reset_outs", {24'd0, outs(0), outs(1)}, 32'd0);
    iRst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      acc = acc | outs(0) | outs(1);
    end
    chk("idle_after_reset", {28'd0, acc}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      setVec(vecs[i]);
      enA = 1'b1;
      capture(0, 0, d1, l1, dn1, rc1, so1, rg1);
      enA = 1'b0;
      chk($sformatf("vec%0d_data", i), {16'd0, d1}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_sload", i), {31'd0, so1}, 32'd1);
      chk($sformatf("vec%0d_done_lat", i), dn1 - l1, 32'd129);
      idle(40);
    end

    setVec(vecs[0]);
    enA = 1'b1;
    capture(0, 1, d1, l1, dn1, rc1, so1, rg1);
    capture(0, 0, d2, l2, dn2, rc2, so2, rg2);
    enA = 1'b0;
    chk("coh_frame1", {16'd0, d1}, 32'h0000A292);
    chk("coh_frame2", {16'd0, d2}, 32'h00002292);
    chk("coh_period", l2 - l1, 32'd161);
    chk("coh_sclk_period", rg1, 32'd8);
    idle(40);

    setVec(vecs[0]);
    enA = 1'b1;
    capture(0, 2, d1, l1, dn1, rc1, so1, rg1);
    chk("drop_data", {16'd0, d1}, 32'h0000A292);
    chk("drop_bits", rc1, 32'd16);
    chk("drop_done_lat", dn1 - l1, 32'd129);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClk);
      if (busA.oSLOAD) cnt++;
    end
    chk("drop_no_reload", cnt, 32'd0);

    enA = 1'b1;
    cnt = 0;
    while (!busA.oSLOAD && cnt < 50) begin
      @(negedge iClk);
      cnt++;
    end
    idle(3);
    chk("pre_reset_active", {28'd0, outs(0)}, 32'h6);
    iRst_n = 1'b0;
    #1;
    chk("midframe_reset", {28'd0, outs(0)}, 32'd0);
    enA = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iClk);
      acc = acc | outs(0);
    end
    chk("post_reset_quiet", {28'd0, acc}, 32'd0);

    setVec(vecs[0]);
    enB = 1'b1;
    capture(1, 0, d1, l1, dn1, rc1, so1, rg1);
    capture(1, 0, d2, l2, dn2, rc2, so2, rg2);
    enB = 1'b0;
    chk("div1_data", {16'd0, d1}, 32'h0000A292);
    chk("div1_done_lat", dn1 - l1, 32'd33);
    chk("div1_sclk_period", rg1, 32'd2);
    chk("div1_period", l2 - l1, 32'd34);
    chk("div1_sload", {31'd0, so2}, 32'd1);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
